// File: rtl/obi_pkg.sv
// Minimal OBI type package for the user-domain read path.
// Provides the configuration record (address/data/id widths) and the
// default request/response structs matching ObiDefaultConfig.
//   obi_cfg_t        : AddrWidth, DataWidth, IdWidth
//   ObiDefaultConfig : 32-bit address, 32-bit data, 1-bit id
//   obi_req_t        : req + A channel (addr, we, be, wdata, aid, a_optional)
//   obi_rsp_t        : gnt, rvalid + R channel (rdata, rid, err)
package obi_pkg;

  typedef struct packed {
    int unsigned AddrWidth;
    int unsigned DataWidth;
    int unsigned IdWidth;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{AddrWidth: 32, DataWidth: 32, IdWidth: 1};

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [0:0]  aid;
    logic        a_optional;
  } obi_a_chan_t;

  typedef struct packed {
    logic        req;
    obi_a_chan_t a;
  } obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [0:0]  rid;
    logic        err;
  } obi_r_chan_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    obi_r_chan_t r;
  } obi_rsp_t;

endpackage

// File: rtl/obi_string_reader.sv
// OBI manager that fetches a NUL-terminated byte string one 32-bit word at a
// time and streams its bytes (little-endian) on a valid/ready interface.
// Ports:
//   clk_i, rst_ni       : clock, asynchronous active-low reset
//   start_i             : start pulse, ignored while busy or in the done cycle
//   base_addr_i         : string start address (word aligned internally)
//   busy_o, done_o      : activity flag, one-cycle completion pulse
//   err_o               : sticky bus error, cleared by the next accepted start
//   len_o               : number of bytes emitted, held after completion
//   byte_o/byte_valid_o/byte_ready_i : output byte stream
//   obi_req_o/obi_rsp_i : OBI read request / response
module obi_string_reader #(
  parameter obi_pkg::obi_cfg_t ObiCfg   = obi_pkg::ObiDefaultConfig,
  parameter type               obi_req_t = obi_pkg::obi_req_t,
  parameter type               obi_rsp_t = obi_pkg::obi_rsp_t,
  parameter int unsigned       MaxBytes  = 32
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            start_i,
  input  logic [ObiCfg.AddrWidth-1:0]     base_addr_i,
  output logic                            busy_o,
  output logic                            done_o,
  output logic                            err_o,
  output logic [$clog2(MaxBytes+1)-1:0]   len_o,
  output logic [7:0]                      byte_o,
  output logic                            byte_valid_o,
  input  logic                            byte_ready_i,
  output obi_req_t                        obi_req_o,
  input  obi_rsp_t                        obi_rsp_i
);

  localparam int unsigned AW = ObiCfg.AddrWidth;
  localparam int unsigned LW = $clog2(MaxBytes + 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_R,
    EMIT,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   word_q, word_d;
  logic [1:0]    idx_q, idx_d;
  logic [LW-1:0] len_q, len_d;
  logic          err_q, err_d;

  logic [7:0]    cur_byte;
  logic [LW-1:0] len_inc;

  assign cur_byte = word_q[8*idx_q +: 8];
  assign len_inc  = len_q + LW'(1);

  assign len_o = len_q;
  assign err_o = err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      word_q  <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    word_d       = word_q;
    idx_d        = idx_q;
    len_d        = len_q;
    err_d        = err_q;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    byte_o       = 8'h00;
    byte_valid_o = 1'b0;

    // Read-only manager: every A-channel field except req/addr is constant.
    obi_req_o        = '0;
    obi_req_o.a.be   = 4'hF;
    obi_req_o.a.addr = addr_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          addr_d  = base_addr_i & ~AW'(3);
          len_d   = '0;
          err_d   = 1'b0;
          state_d = REQ;
        end
      end

      REQ: begin
        busy_o        = 1'b1;
        obi_req_o.req = 1'b1;
        if (obi_rsp_i.gnt) begin
          state_d = WAIT_R;
        end
      end

      WAIT_R: begin
        busy_o = 1'b1;
        if (obi_rsp_i.rvalid) begin
          // A non-zero rid cannot belong to our single aid=0 transaction.
          if (obi_rsp_i.r.err || (obi_rsp_i.r.rid != '0)) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            word_d  = obi_rsp_i.r.rdata;
            idx_d   = '0;
            state_d = EMIT;
          end
        end
      end

      EMIT: begin
        busy_o = 1'b1;
        byte_o = cur_byte;
        if (cur_byte == 8'h00) begin
          // The terminator itself is never presented downstream.
          state_d = DONE;
        end else begin
          byte_valid_o = 1'b1;
          if (byte_ready_i) begin
            len_d = len_inc;
            idx_d = idx_q + 2'd1;
            if (len_inc == LW'(MaxBytes)) begin
              state_d = DONE;
            end else if (idx_q == 2'd3) begin
              addr_d  = addr_q + AW'(4);
              state_d = REQ;
            end
          end
        end
      end

      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_obi_string_reader.sv
// Self-checking bench for obi_string_reader. A word-addressed memory model
// answers OBI reads with configurable grant delay, read latency and an
// optional error word; a reference model derives the expected byte stream,
// request addresses, final length and error flag from the memory contents.
module tb_obi_string_reader;

  localparam int MaxBytes = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [31:0]       base_addr = '0;
  logic              busy, done, err;
  logic [5:0]        len;
  logic [7:0]        byte_data;
  logic              byte_valid;
  logic              byte_ready = 1'b1;
  obi_pkg::obi_req_t obi_req;
  obi_pkg::obi_rsp_t obi_rsp = '0;

  obi_string_reader #(
    .MaxBytes(MaxBytes)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .base_addr_i (base_addr),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err),
    .len_o       (len),
    .byte_o      (byte_data),
    .byte_valid_o(byte_valid),
    .byte_ready_i(byte_ready),
    .obi_req_o   (obi_req),
    .obi_rsp_i   (obi_rsp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Memory image and test configuration
  logic [31:0] mem [0:63];
  int gnt_delay  = 0;
  int rsp_lat    = 1;
  int ready_mode = 0;
  int err_idx    = -1;

  // Reference model outputs
  logic [7:0]  exp_bytes [$];
  logic [31:0] exp_addr [$];
  int          exp_len;
  logic        exp_err;

  // Observation state
  int          cyc = 0;
  int          done_count = 0;
  int          req_count = 0;
  int          start_cyc = 0;
  int          first_valid_cyc = -1;
  logic [7:0]  first_byte = 8'h00;
  int          emitted = 0;
  bit          want_first = 1'b0;
  logic [31:0] first_req_addr = '0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic flagFailure(input string name, input int actual, input int required);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got %0d, required %0d", name, actual, required);
  endtask

  task automatic loadString(input int kind);
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    if (kind == 0) begin
      mem[0] = 32'h50264C4A;
      mem[1] = 32'h20732753;
      mem[2] = 32'h43495341;
      mem[3] = 32'h00000000;
    end else begin
      for (int i = 0; i < 16; i++) mem[i] = 32'h41414141;
    end
  endtask

  // Walk the string as the reader should: word by word, bytes in ascending
  // address order, stopping at NUL, at the byte cap or at a failing read.
  task automatic buildModel(input logic [31:0] base, input int eidx);
    logic [31:0] a;
    logic [31:0] w;
    logic [7:0]  b;
    int          n;
    bit          stop;
    exp_bytes.delete();
    exp_addr.delete();
    a = base & ~32'h3;
    n = 0;
    stop = 1'b0;
    exp_err = 1'b0;
    while (!stop) begin
      exp_addr.push_back(a);
      if (int'(a[7:2]) == eidx) begin
        exp_err = 1'b1;
        stop = 1'b1;
      end else begin
        w = mem[a[7:2]];
        for (int i = 0; i < 4 && !stop; i++) begin
          b = w[8*i +: 8];
          if (b == 8'h00) stop = 1'b1;
          else begin
            exp_bytes.push_back(b);
            n++;
            if (n == MaxBytes) stop = 1'b1;
          end
        end
        a = a + 32'd4;
      end
    end
    exp_len = n;
  endtask

  // Subordinate responder, ready generator and compare process, all
  // evaluated mid-cycle so every value is stable around the rising edge.
  initial begin : responder
    int          pend;
    int          wait_cnt;
    int          resp_idx;
    bit          resp_err;
    logic [31:0] held_addr;
    logic        prev_valid, prev_ready, prev_done;
    logic [7:0]  prev_byte;
    pend = 0; wait_cnt = 0; resp_idx = 0; resp_err = 1'b0; held_addr = '0;
    prev_valid = 1'b0; prev_ready = 1'b0; prev_done = 1'b0; prev_byte = '0;
    forever begin
      @(negedge clk);
      cyc++;
      obi_rsp = '0;
      if (!rst_n) begin
        pend = 0;
        wait_cnt = 0;
        prev_valid = 1'b0;
        prev_done = 1'b0;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            obi_rsp.rvalid = 1'b1;
            if (resp_err) obi_rsp.r.err = 1'b1;
            else obi_rsp.r.rdata = mem[resp_idx];
          end
        end
        if (obi_req.req) begin
          if (wait_cnt == 0) held_addr = obi_req.a.addr;
          else checkOutput("addr_held", obi_req.a.addr, held_addr);
          if (wait_cnt == gnt_delay) begin
            obi_rsp.gnt = 1'b1;
            req_count++;
            if (want_first) begin
              first_req_addr = obi_req.a.addr;
              want_first = 1'b0;
            end
            if (exp_addr.size() == 0) flagFailure("extra_request", req_count, 0);
            else checkOutput("req_addr", obi_req.a.addr, exp_addr.pop_front());
            resp_idx = int'(obi_req.a.addr[7:2]);
            resp_err = (resp_idx == err_idx);
            pend = rsp_lat;
            wait_cnt = 0;
          end else begin
            wait_cnt++;
          end
        end else if (wait_cnt != 0) begin
          flagFailure("req_dropped", wait_cnt, 0);
          wait_cnt = 0;
        end

        byte_ready = (ready_mode != 0) ? ((cyc % 3) == 0) : 1'b1;

        if (start && !busy && !done) start_cyc = cyc;
        if (prev_valid && !prev_ready) begin
          checkOutput("hold_valid", byte_valid, 1);
          checkOutput("hold_byte", byte_data, prev_byte);
        end
        if (byte_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (byte_valid && byte_ready) begin
          if (exp_bytes.size() == 0) flagFailure("extra_byte", byte_data, 0);
          else checkOutput("byte", byte_data, exp_bytes.pop_front());
          if (emitted == 0) first_byte = byte_data;
          emitted++;
        end
        if (done) begin
          done_count++;
          checkOutput("done_width", prev_done, 0);
          checkOutput("busy_at_done", busy, 0);
          checkOutput("len_at_done", len, exp_len);
          checkOutput("err_at_done", err, exp_err);
          checkOutput("bytes_left", exp_bytes.size(), 0);
          checkOutput("reqs_left", exp_addr.size(), 0);
        end
        prev_valid = byte_valid;
        prev_ready = byte_ready;
        prev_byte  = byte_data;
        prev_done  = done;
      end
    end
  end

  // One complete string fetch: configure the subordinate, build the
  // expectation, pulse start and wait (bounded) for the done pulse.
  task automatic applyStimulus(input logic [31:0] base, input int gd, input int lat,
                               input int rmode, input int eidx, input bit busy_poke);
    int d0;
    int guard;
    gnt_delay  = gd;
    rsp_lat    = lat;
    ready_mode = rmode;
    err_idx    = eidx;
    buildModel(base, eidx);
    d0 = done_count;
    emitted = 0;
    first_valid_cyc = -1;
    want_first = 1'b1;
    @(posedge clk); #1;
    base_addr = base;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("busy_after_start", busy, 1);
    checkOutput("err_cleared", err, 0);
    checkOutput("len_cleared", len, 0);
    if (busy_poke) begin
      repeat (2) @(posedge clk);
      #1;
      base_addr = 32'h40;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    guard = 0;
    while (done_count == d0 && guard < 3000) begin
      @(posedge clk);
      guard++;
    end
    if (done_count == d0) flagFailure("done_timeout", guard, 3000);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("done_pulses", done_count - d0, 1);
    checkOutput("len_hold", len, exp_len);
    checkOutput("busy_idle", busy, 0);
  endtask

  initial begin : stimulus
    int r0;
    int d0;
    rst_n = 1'b0;
    loadString(0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_err", err, 0);
    checkOutput("reset_len", len, 0);
    checkOutput("reset_valid", byte_valid, 0);
    checkOutput("reset_req", obi_req.req, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] string, 2-cycle read latency, ready tied high");
    r0 = req_count;
    applyStimulus(32'h0, 0, 2, 0, -1, 1'b0);
    checkOutput("t1_len", len, 12);
    checkOutput("t1_reqs", req_count - r0, 4);
    checkOutput("t1_first_byte", first_byte, 8'h4A);
    checkOutput("t1_err", err, 0);

    $display("[TB] string, ready one cycle in three");
    r0 = req_count;
    applyStimulus(32'h0, 0, 2, 1, -1, 1'b0);
    checkOutput("t2_reqs", req_count - r0, 4);
    checkOutput("t2_len", len, 12);

    $display("[TB] string, grant delayed 5 cycles");
    r0 = req_count;
    applyStimulus(32'h0, 5, 1, 0, -1, 1'b0);
    checkOutput("t3_reqs", req_count - r0, 4);

    $display("[TB] zero-wait subordinate latency");
    applyStimulus(32'h0, 0, 1, 0, -1, 1'b0);
    checkOutput("first_valid_latency", first_valid_cyc - start_cyc, 3);

    $display("[TB] unterminated string hits byte cap");
    loadString(1);
    r0 = req_count;
    applyStimulus(32'h0, 0, 1, 0, -1, 1'b0);
    checkOutput("t4_len", len, 32);
    checkOutput("t4_reqs", req_count - r0, 8);

    $display("[TB] read error on second word");
    loadString(0);
    applyStimulus(32'h0, 0, 2, 0, 1, 1'b0);
    checkOutput("t5_len", len, 4);
    checkOutput("t5_err", err, 1);

    $display("[TB] reset in the middle of a request");
    d0 = done_count;
    gnt_delay = 3;
    rsp_lat = 1;
    @(posedge clk); #1;
    base_addr = 32'h0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_req_drop", obi_req.req, 0);
    checkOutput("rst_busy_drop", busy, 0);
    exp_bytes.delete();
    exp_addr.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("rst_stays_idle", busy, 0);
    checkOutput("rst_req_idle", obi_req.req, 0);
    checkOutput("rst_no_done", done_count - d0, 0);

    $display("[TB] unaligned base with start pulse while busy");
    r0 = req_count;
    applyStimulus(32'h103, 0, 2, 0, -1, 1'b1);
    checkOutput("t6_first_addr", first_req_addr, 32'h100);
    checkOutput("t6_reqs", req_count - r0, 4);
    checkOutput("t6_len", len, 12);
    checkOutput("t6_err", err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
